// File: rtl/click_event_queue_pkg.sv
// Shared types for the click event queue: window FSM states and event type.
// Used by the top, the event FIFO and the handshake interface.
package click_evt_pkg;

  localparam int CNT_W_DFLT = 3;

  typedef logic [CNT_W_DFLT-1:0] click_evt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/click_event_queue_if.sv
// Valid/ready event stream from the click queue to the register logic.
// The master side presents the FIFO head; the slave side accepts it.
interface click_event_queue_if #(
  parameter int CNT_W = click_evt_pkg::CNT_W_DFLT
) ();

  logic [CNT_W-1:0] evt_data;
  logic             evt_valid;
  logic             evt_ready;

  modport master (
    output evt_data,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_data,
    input  evt_valid,
    output evt_ready
  );

endinterface

// File: rtl/click_event_queue_evt_fifo.sv
// First-word-fall-through synchronous FIFO holding completed click events.
// Head reads straight from storage; it is zero while the FIFO is empty.
module evt_fifo
  import click_evt_pkg::*;
#(
  parameter int W     = CNT_W_DFLT,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);

  // A push into a full FIFO is still legal when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/click_event_queue.sv
// Groups debounced press pulses into multi-click events and queues them.
// Optional CLICK_EVENT_QUEUE_DROP_CNT_EN adds a saturating drop counter.
module click_event_queue
  import click_evt_pkg::*;
#(
  parameter int GAP_CYCLES = 50000,
  parameter int MAX_CLICKS = 7,
  parameter int CNT_W      = CNT_W_DFLT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  press,
  click_event_queue_if.master   evt,
  output logic                  busy,
  output logic                  fifo_full,
  output logic                  drop
`ifdef CLICK_EVENT_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt,
  input  logic                  drop_clr
`endif
);

  localparam int TW = $clog2(GAP_CYCLES);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_EMIT    = EMIT;

  localparam logic [TW-1:0]    RELOAD = TW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX   = CNT_W'(MAX_CLICKS);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [TW-1:0]    timer;

  logic             emit;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] head;

  assign cnt_nx = cnt + CNT_W'(1);
  assign emit   = (state == ST_EMIT);
  assign busy   = (state != ST_IDLE);

  assign pop  = !empty && evt.evt_ready;
  assign push = emit && (!full || pop);
  assign drop = emit && full && !pop;

  assign evt.evt_valid = !empty;
  assign evt.evt_data  = head;
  assign fifo_full     = full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      timer <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (press) begin
            cnt   <= CNT_W'(1);
            timer <= RELOAD;
            state <= ST_COLLECT;
          end
        end
        (state == ST_COLLECT): begin
          if (press) begin
            cnt   <= cnt_nx;
            timer <= RELOAD;
            if (cnt_nx == CMAX) begin
              state <= ST_EMIT;
            end
          end else if (timer == '0) begin
            state <= ST_EMIT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        (state == ST_EMIT): begin
          // A press here starts the next window so no click is lost.
          if (press) begin
            cnt   <= CNT_W'(1);
            timer <= RELOAD;
            state <= ST_COLLECT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  evt_fifo #(
    .W     (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cnt),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef CLICK_EVENT_QUEUE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= {7'd0, drop};
    end else if (drop && (drop_cnt != 8'hff)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
